// File: rtl/azadi_trap_ctrl_pkg.sv
// rtl/azadi_trap_ctrl_pkg.sv - types, cause codes and FSM encodings for the azadi trap controller
package azadi_trap_ctrl_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_JUMP = 3'd1,
        PC_EXC  = 3'd2,
        PC_ERET = 3'd3,
        PC_DRET = 3'd4
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;

    typedef enum logic [2:0] {
        DBG_CAUSE_NONE    = 3'd0,
        DBG_CAUSE_EBREAK  = 3'd1,
        DBG_CAUSE_TRIGGER = 3'd2,
        DBG_CAUSE_HALTREQ = 3'd3,
        DBG_CAUSE_STEP    = 3'd4
    } dbg_cause_e;

    typedef logic [2:0] ctrl_fsm_e;
    localparam ctrl_fsm_e CTRL_RESET     = 3'd0;
    localparam ctrl_fsm_e CTRL_BOOT_SET  = 3'd1;
    localparam ctrl_fsm_e CTRL_DECODE    = 3'd2;
    localparam ctrl_fsm_e CTRL_FLUSH     = 3'd3;
    localparam ctrl_fsm_e CTRL_IRQ_TAKEN = 3'd4;
    localparam ctrl_fsm_e CTRL_DBG_TAKEN = 3'd5;

    // What the FLUSH cycle has to do, decided when the sync event is accepted
    typedef logic [2:0] flush_kind_e;
    localparam flush_kind_e FLUSH_EXC      = 3'd0;
    localparam flush_kind_e FLUSH_EXC_DBG  = 3'd1;
    localparam flush_kind_e FLUSH_EBRK_DBG = 3'd2;
    localparam flush_kind_e FLUSH_MRET     = 3'd3;
    localparam flush_kind_e FLUSH_DRET     = 3'd4;

    localparam logic [5:0] EXC_CAUSE_INSN_ADDR_FAULT  = 6'h01;
    localparam logic [5:0] EXC_CAUSE_ILLEGAL_INSN     = 6'h02;
    localparam logic [5:0] EXC_CAUSE_BREAKPOINT       = 6'h03;
    localparam logic [5:0] EXC_CAUSE_LOAD_ACCESS      = 6'h05;
    localparam logic [5:0] EXC_CAUSE_STORE_ACCESS     = 6'h07;
    localparam logic [5:0] EXC_CAUSE_ECALL_UMODE      = 6'h08;
    localparam logic [5:0] EXC_CAUSE_ECALL_MMODE      = 6'h0B;
    localparam logic [5:0] EXC_CAUSE_IRQ_SOFTWARE_M   = {1'b1, 5'd3};
    localparam logic [5:0] EXC_CAUSE_IRQ_TIMER_M      = {1'b1, 5'd7};
    localparam logic [5:0] EXC_CAUSE_IRQ_EXTERNAL_M   = {1'b1, 5'd11};
    localparam logic [5:0] EXC_CAUSE_IRQ_FAST_0       = {1'b1, 5'd16};
    localparam logic [5:0] EXC_CAUSE_IRQ_NM           = {1'b1, 5'd31};

endpackage

// File: rtl/azadi_trap_ctrl_if.sv
// rtl/azadi_trap_ctrl_if.sv - ID-stage event inputs and PC/CSR redirect outputs of the trap controller
interface azadi_trap_ctrl_if;
    import azadi_trap_ctrl_pkg::*;

    logic        fetch_en_i;
    logic        instr_valid_i;
    logic        instr_fetch_err_i;
    logic        illegal_insn_i;
    logic        ecall_insn_i;
    logic        ebreak_insn_i;
    logic        mret_insn_i;
    logic        dret_insn_i;
    logic        lsu_load_err_i;
    logic        lsu_store_err_i;
    irqs_t       irqs_i;
    logic        irq_nm_i;
    logic        csr_mstatus_mie_i;
    irqs_t       csr_mie_i;
    priv_lvl_e   priv_mode_i;
    logic        debug_req_i;
    logic        instr_req_o;
    logic        pc_set_o;
    pc_sel_e     pc_mux_o;
    exc_pc_sel_e exc_pc_mux_o;
    logic [5:0]  exc_cause_o;
    logic        csr_save_cause_o;
    logic        csr_restore_mret_o;
    logic        csr_restore_dret_o;
    logic        flush_id_o;
    logic        debug_mode_o;
    dbg_cause_e  debug_cause_o;
    logic        ctrl_busy_o;

    modport slave (
        input  fetch_en_i, instr_valid_i, instr_fetch_err_i, illegal_insn_i, ecall_insn_i,
               ebreak_insn_i, mret_insn_i, dret_insn_i, lsu_load_err_i, lsu_store_err_i,
               irqs_i, irq_nm_i, csr_mstatus_mie_i, csr_mie_i, priv_mode_i, debug_req_i,
        output instr_req_o, pc_set_o, pc_mux_o, exc_pc_mux_o, exc_cause_o, csr_save_cause_o,
               csr_restore_mret_o, csr_restore_dret_o, flush_id_o, debug_mode_o,
               debug_cause_o, ctrl_busy_o
    );

    modport master (
        output fetch_en_i, instr_valid_i, instr_fetch_err_i, illegal_insn_i, ecall_insn_i,
               ebreak_insn_i, mret_insn_i, dret_insn_i, lsu_load_err_i, lsu_store_err_i,
               irqs_i, irq_nm_i, csr_mstatus_mie_i, csr_mie_i, priv_mode_i, debug_req_i,
        input  instr_req_o, pc_set_o, pc_mux_o, exc_pc_mux_o, exc_cause_o, csr_save_cause_o,
               csr_restore_mret_o, csr_restore_dret_o, flush_id_o, debug_mode_o,
               debug_cause_o, ctrl_busy_o
    );

endinterface

// File: rtl/azadi_trap_ctrl_irq_prio.sv
// rtl/azadi_trap_ctrl_irq_prio.sv - interrupt pending detection and cause priority encoder
module azadi_irq_prio
    import azadi_trap_ctrl_pkg::*;
(
    input  irqs_t      irqs_i,
    input  irqs_t      csr_mie_i,
    input  logic       mie_i,
    input  logic       irq_nm_i,
    input  logic       debug_mode_i,
    output logic       irq_pending_o,
    output logic [5:0] irq_cause_o
);

    irqs_t irq_en;

    always_comb begin
        irq_en        = irqs_t'(irqs_i & csr_mie_i);
        irq_pending_o = !debug_mode_i && (irq_nm_i || (mie_i && (|irq_en)));
        irq_cause_o   = '0;
        if (irq_nm_i) begin
            irq_cause_o = EXC_CAUSE_IRQ_NM;
        end else if (|irq_en.irq_fast) begin
            // Walk downwards so the lowest-numbered fast line wins
            for (int i = 14; i >= 0; i--) begin
                if (irq_en.irq_fast[i]) begin
                    irq_cause_o = EXC_CAUSE_IRQ_FAST_0 + 6'(i);
                end
            end
        end else if (irq_en.irq_external) begin
            irq_cause_o = EXC_CAUSE_IRQ_EXTERNAL_M;
        end else if (irq_en.irq_software) begin
            irq_cause_o = EXC_CAUSE_IRQ_SOFTWARE_M;
        end else if (irq_en.irq_timer) begin
            irq_cause_o = EXC_CAUSE_IRQ_TIMER_M;
        end
    end

endmodule

// File: rtl/azadi_trap_ctrl.sv
// rtl/azadi_trap_ctrl.sv - trap/PC-redirect FSM: boot, exceptions, interrupts, mret/dret, debug entry
module azadi_trap_ctrl
    import azadi_trap_ctrl_pkg::*;
#(
    parameter bit DebugEn = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    azadi_trap_ctrl_if.slave bus
);

    ctrl_fsm_e   state_q, state_d;
    flush_kind_e flush_kind_q, flush_kind_d;
    logic [5:0]  exc_cause_q, exc_cause_d;
    logic        debug_mode_q, debug_mode_d;
    dbg_cause_e  debug_cause_q, debug_cause_d;

    logic        irq_pending;
    logic [5:0]  irq_cause;
    logic        sync_evt;
    flush_kind_e sync_kind;
    logic [5:0]  sync_cause;
    logic        dbg_take;

    azadi_irq_prio u_irq_prio (
        .irqs_i        (bus.irqs_i),
        .csr_mie_i     (bus.csr_mie_i),
        .mie_i         (bus.csr_mstatus_mie_i),
        .irq_nm_i      (bus.irq_nm_i),
        .debug_mode_i  (debug_mode_q),
        .irq_pending_o (irq_pending),
        .irq_cause_o   (irq_cause)
    );

    always_comb begin
        sync_evt   = 1'b1;
        sync_kind  = FLUSH_EXC;
        sync_cause = '0;
        if (bus.instr_fetch_err_i) begin
            sync_cause = EXC_CAUSE_INSN_ADDR_FAULT;
        end else if (bus.illegal_insn_i) begin
            sync_cause = EXC_CAUSE_ILLEGAL_INSN;
        end else if (bus.ecall_insn_i) begin
            sync_cause = (bus.priv_mode_i == PRIV_LVL_M) ? EXC_CAUSE_ECALL_MMODE
                                                         : EXC_CAUSE_ECALL_UMODE;
        end else if (bus.ebreak_insn_i) begin
            sync_cause = EXC_CAUSE_BREAKPOINT;
            if (debug_mode_q) sync_kind = FLUSH_EBRK_DBG;
        end else if (bus.lsu_load_err_i) begin
            sync_cause = EXC_CAUSE_LOAD_ACCESS;
        end else if (bus.lsu_store_err_i) begin
            sync_cause = EXC_CAUSE_STORE_ACCESS;
        end else if (bus.mret_insn_i) begin
            if (bus.priv_mode_i == PRIV_LVL_U) sync_cause = EXC_CAUSE_ILLEGAL_INSN;
            else                               sync_kind  = FLUSH_MRET;
        end else if (bus.dret_insn_i) begin
            if (DebugEn && debug_mode_q) sync_kind  = FLUSH_DRET;
            else                         sync_cause = EXC_CAUSE_ILLEGAL_INSN;
        end else begin
            sync_evt = 1'b0;
        end
        // Exceptions raised inside debug mode re-enter the debug exception vector unsaved
        if (sync_kind == FLUSH_EXC && debug_mode_q) sync_kind = FLUSH_EXC_DBG;
    end

    assign dbg_take = DebugEn && bus.debug_req_i && !debug_mode_q;

    always_comb begin
        state_d       = state_q;
        flush_kind_d  = flush_kind_q;
        exc_cause_d   = exc_cause_q;
        debug_mode_d  = debug_mode_q;
        debug_cause_d = debug_cause_q;
        case (state_q)
            CTRL_RESET:    if (bus.fetch_en_i) state_d = CTRL_BOOT_SET;
            CTRL_BOOT_SET: state_d = CTRL_DECODE;
            CTRL_DECODE: begin
                if (dbg_take) begin
                    state_d       = CTRL_DBG_TAKEN;
                    debug_cause_d = DBG_CAUSE_HALTREQ;
                end else if (bus.instr_valid_i && sync_evt) begin
                    state_d      = CTRL_FLUSH;
                    flush_kind_d = sync_kind;
                    if (sync_kind != FLUSH_MRET && sync_kind != FLUSH_DRET) exc_cause_d = sync_cause;
                end else if (irq_pending) begin
                    state_d     = CTRL_IRQ_TAKEN;
                    exc_cause_d = irq_cause;
                end
            end
            CTRL_FLUSH: begin
                state_d = CTRL_DECODE;
                if (flush_kind_q == FLUSH_DRET) debug_mode_d = 1'b0;
            end
            CTRL_IRQ_TAKEN: state_d = CTRL_DECODE;
            CTRL_DBG_TAKEN: begin
                state_d      = CTRL_DECODE;
                debug_mode_d = 1'b1;
            end
            default: state_d = CTRL_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= CTRL_RESET;
            flush_kind_q  <= FLUSH_EXC;
            exc_cause_q   <= '0;
            debug_mode_q  <= 1'b0;
            debug_cause_q <= DBG_CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            flush_kind_q  <= flush_kind_d;
            exc_cause_q   <= exc_cause_d;
            debug_mode_q  <= debug_mode_d;
            debug_cause_q <= debug_cause_d;
        end
    end

    always_comb begin
        bus.instr_req_o        = (state_q != CTRL_RESET);
        bus.ctrl_busy_o        = (state_q != CTRL_RESET);
        bus.pc_set_o           = 1'b0;
        bus.pc_mux_o           = PC_BOOT;
        bus.exc_pc_mux_o       = EXC_PC_EXC;
        bus.csr_save_cause_o   = 1'b0;
        bus.csr_restore_mret_o = 1'b0;
        bus.csr_restore_dret_o = 1'b0;
        bus.flush_id_o         = 1'b0;
        bus.exc_cause_o        = exc_cause_q;
        bus.debug_mode_o       = debug_mode_q;
        bus.debug_cause_o      = debug_cause_q;
        case (state_q)
            CTRL_BOOT_SET: bus.pc_set_o = 1'b1;
            CTRL_FLUSH: begin
                bus.pc_set_o   = 1'b1;
                bus.flush_id_o = 1'b1;
                bus.pc_mux_o   = PC_EXC;
                case (flush_kind_q)
                    FLUSH_EXC:      bus.csr_save_cause_o = 1'b1;
                    FLUSH_EXC_DBG:  bus.exc_pc_mux_o     = EXC_PC_DBG_EXC;
                    FLUSH_EBRK_DBG: bus.exc_pc_mux_o     = EXC_PC_DBD;
                    FLUSH_MRET: begin
                        bus.pc_mux_o           = PC_ERET;
                        bus.csr_restore_mret_o = 1'b1;
                    end
                    FLUSH_DRET: begin
                        bus.pc_mux_o           = PC_DRET;
                        bus.csr_restore_dret_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            CTRL_IRQ_TAKEN: begin
                bus.pc_set_o         = 1'b1;
                bus.flush_id_o       = 1'b1;
                bus.pc_mux_o         = PC_EXC;
                bus.exc_pc_mux_o     = EXC_PC_IRQ;
                bus.csr_save_cause_o = 1'b1;
            end
            CTRL_DBG_TAKEN: begin
                bus.pc_set_o     = 1'b1;
                bus.flush_id_o   = 1'b1;
                bus.pc_mux_o     = PC_EXC;
                bus.exc_pc_mux_o = EXC_PC_DBD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_azadi_trap_ctrl.sv
// tb/tb_azadi_trap_ctrl.sv - scoreboard bench for azadi_trap_ctrl redirects, causes and debug mode
module tb_azadi_trap_ctrl;
    import azadi_trap_ctrl_pkg::*;

    typedef struct {
        pc_sel_e     pc_mux;
        exc_pc_sel_e exc_mux;
        logic        save;
        logic        mret;
        logic        dret;
        logic        flush;
        logic [5:0]  cause;
    } exp_t;

    // flags order: {fetch_err, illegal, ecall, ebreak, load_err, store_err, mret, dret}
    typedef struct {
        logic [7:0] flags;
        priv_lvl_e  priv;
        logic [5:0] cause;
    } sync_vec_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic prev_pc_set = 1'b0;

    azadi_trap_ctrl_if bus ();

    azadi_trap_ctrl #(.DebugEn(1'b1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input pc_sel_e pm, input exc_pc_sel_e em, input logic save,
                        input logic mret, input logic dret, input logic flush, input logic [5:0] cause);
        exp_t e;
        e.pc_mux = pm; e.exc_mux = em; e.save = save; e.mret = mret;
        e.dret = dret; e.flush = flush; e.cause = cause;
        sb.push_back(e);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (bus.pc_set_o === 1'b1) begin
            check("pc_set_gap", prev_pc_set, 1'b0);
            if (sb.size() == 0) begin
                check("sb_unexpected_pc_set", bus.pc_set_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check("pc_mux", bus.pc_mux_o, e.pc_mux);
                check("exc_pc_mux", bus.exc_pc_mux_o, e.exc_mux);
                check("save_cause", bus.csr_save_cause_o, e.save);
                check("restore_mret", bus.csr_restore_mret_o, e.mret);
                check("restore_dret", bus.csr_restore_dret_o, e.dret);
                check("flush_id", bus.flush_id_o, e.flush);
                if (e.save) check("exc_cause", bus.exc_cause_o, e.cause);
            end
        end
        prev_pc_set <= bus.pc_set_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_instr();
        bus.instr_valid_i = 1'b0;
        {bus.instr_fetch_err_i, bus.illegal_insn_i, bus.ecall_insn_i, bus.ebreak_insn_i,
         bus.lsu_load_err_i, bus.lsu_store_err_i, bus.mret_insn_i, bus.dret_insn_i} = 8'h00;
    endtask

    task automatic sync_instr(input logic [7:0] f, input priv_lvl_e p);
        bus.priv_mode_i   = p;
        bus.instr_valid_i = 1'b1;
        {bus.instr_fetch_err_i, bus.illegal_insn_i, bus.ecall_insn_i, bus.ebreak_insn_i,
         bus.lsu_load_err_i, bus.lsu_store_err_i, bus.mret_insn_i, bus.dret_insn_i} = f;
        step();
        clr_instr();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sync_vec_t tbl[7];
        tbl = '{
            '{8'h20, PRIV_LVL_U, 6'h08},   // ecall U
            '{8'h20, PRIV_LVL_M, 6'h0B},   // ecall M
            '{8'hC0, PRIV_LVL_M, 6'h01},   // fetch_err beats illegal
            '{8'h18, PRIV_LVL_M, 6'h03},   // ebreak beats load_err
            '{8'h0C, PRIV_LVL_M, 6'h05},   // load_err beats store_err
            '{8'h04, PRIV_LVL_M, 6'h07},   // store_err
            '{8'h02, PRIV_LVL_U, 6'h02}    // mret in U-mode is illegal
        };
        rst_ni                = 1'b0;
        bus.fetch_en_i        = 1'b0;
        bus.irqs_i            = '0;
        bus.irq_nm_i          = 1'b0;
        bus.csr_mstatus_mie_i = 1'b0;
        bus.csr_mie_i         = '0;
        bus.priv_mode_i       = PRIV_LVL_M;
        bus.debug_req_i       = 1'b0;
        clr_instr();
        repeat (2) step();
        check("rst_instr_req", bus.instr_req_o, 1'b0);
        check("rst_pc_set", bus.pc_set_o, 1'b0);
        check("rst_pc_mux", bus.pc_mux_o, PC_BOOT);
        check("rst_exc_pc_mux", bus.exc_pc_mux_o, EXC_PC_EXC);
        check("rst_exc_cause", bus.exc_cause_o, 6'h00);
        check("rst_debug_cause", bus.debug_cause_o, DBG_CAUSE_NONE);
        check("rst_busy", bus.ctrl_busy_o, 1'b0);
        check("rst_debug_mode", bus.debug_mode_o, 1'b0);

        // Boot
        rst_ni = 1'b1;
        bus.fetch_en_i = 1'b1;
        push(PC_BOOT, EXC_PC_EXC, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        step();
        check("boot_instr_req", bus.instr_req_o, 1'b1);
        check("boot_busy", bus.ctrl_busy_o, 1'b1);
        bus.fetch_en_i = 1'b0;
        step();
        check("decode_instr_req", bus.instr_req_o, 1'b1);

        // Synchronous exception causes and priorities
        foreach (tbl[i]) begin
            push(PC_EXC, EXC_PC_EXC, 1'b1, 1'b0, 1'b0, 1'b1, tbl[i].cause);
            sync_instr(tbl[i].flags, tbl[i].priv);
        end

        // Event flags without instr_valid_i are ignored
        bus.illegal_insn_i = 1'b1;
        repeat (2) step();
        clr_instr();

        // mret in M-mode
        push(PC_ERET, EXC_PC_EXC, 1'b0, 1'b1, 1'b0, 1'b1, 6'h00);
        sync_instr(8'h02, PRIV_LVL_M);

        // dret outside debug mode is illegal
        push(PC_EXC, EXC_PC_EXC, 1'b1, 1'b0, 1'b0, 1'b1, 6'h02);
        sync_instr(8'h01, PRIV_LVL_M);

        // fast[3] and timer pending and enabled -> fast[3] wins
        bus.irqs_i.irq_fast[3]    = 1'b1;
        bus.irqs_i.irq_timer      = 1'b1;
        bus.csr_mie_i             = bus.irqs_i;
        bus.csr_mstatus_mie_i     = 1'b1;
        push(PC_EXC, EXC_PC_IRQ, 1'b1, 1'b0, 1'b0, 1'b1, 6'h33);
        step();
        bus.irqs_i = '0;
        step();

        // Same lines with global enable off: nothing taken
        bus.irqs_i.irq_fast[3] = 1'b1;
        bus.irqs_i.irq_timer   = 1'b1;
        bus.csr_mstatus_mie_i  = 1'b0;
        repeat (3) step();
        bus.irqs_i = '0;

        // NMI ignores the enables
        bus.irq_nm_i = 1'b1;
        push(PC_EXC, EXC_PC_IRQ, 1'b1, 1'b0, 1'b0, 1'b1, 6'h3F);
        step();
        bus.irq_nm_i = 1'b0;
        step();

        // Illegal and external irq together: exception first, irq on return to DECODE
        bus.irqs_i.irq_external   = 1'b1;
        bus.csr_mie_i             = '0;
        bus.csr_mie_i.irq_external = 1'b1;
        bus.csr_mstatus_mie_i     = 1'b1;
        bus.instr_valid_i         = 1'b1;
        bus.illegal_insn_i        = 1'b1;
        push(PC_EXC, EXC_PC_EXC, 1'b1, 1'b0, 1'b0, 1'b1, 6'h02);
        push(PC_EXC, EXC_PC_IRQ, 1'b1, 1'b0, 1'b0, 1'b1, 6'h2B);
        step();
        clr_instr();
        step();
        step();
        bus.irqs_i = '0;
        step();

        // Debug entry; a held debug_req_i is ignored once in debug mode
        bus.debug_req_i = 1'b1;
        push(PC_EXC, EXC_PC_DBD, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
        step();
        check("dbg_taken_mode", bus.debug_mode_o, 1'b0);
        step();
        check("dbg_mode_on", bus.debug_mode_o, 1'b1);
        check("dbg_cause", bus.debug_cause_o, DBG_CAUSE_HALTREQ);
        step();
        bus.debug_req_i = 1'b0;

        // Interrupts masked in debug mode
        bus.irq_nm_i = 1'b1;
        repeat (2) step();
        bus.irq_nm_i = 1'b0;

        // Exception and ebreak inside debug mode
        push(PC_EXC, EXC_PC_DBG_EXC, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
        sync_instr(8'h40, PRIV_LVL_M);
        push(PC_EXC, EXC_PC_DBD, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
        sync_instr(8'h10, PRIV_LVL_M);

        // dret leaves debug mode the cycle after FLUSH
        push(PC_DRET, EXC_PC_EXC, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00);
        bus.instr_valid_i = 1'b1;
        bus.dret_insn_i   = 1'b1;
        step();
        clr_instr();
        check("dret_flush_mode", bus.debug_mode_o, 1'b1);
        step();
        check("dret_mode_off", bus.debug_mode_o, 1'b0);

        // Reset while in DBG_TAKEN
        bus.debug_req_i = 1'b1;
        push(PC_EXC, EXC_PC_DBD, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
        step();
        bus.debug_req_i = 1'b0;
        rst_ni = 1'b0;
        step();
        check("rst2_debug_mode", bus.debug_mode_o, 1'b0);
        check("rst2_pc_set", bus.pc_set_o, 1'b0);
        check("rst2_flush", bus.flush_id_o, 1'b0);
        check("rst2_save", bus.csr_save_cause_o, 1'b0);
        check("rst2_busy", bus.ctrl_busy_o, 1'b0);
        check("rst2_instr_req", bus.instr_req_o, 1'b0);
        step();

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
